usbf_dma_svc: RTL and testbench

// - Host-side responder for the endpoint DMA handshake: accepts dma_req from NUM_EP endpoint register files and returns a one-cycle dma_ack per word moved.
// - Round-robin arbitration with optional same-channel bursting; each granted word is run as one handshake on a simple host bus.
// - Per-channel timeout and error capture.
// - Sits between the endpoint register files and the system DMA/bus fabric, in the wclk domain (named clk here).

---
 rtl/usbf_dma_pkg.sv | 30 +++
 rtl/usbf_rr_arb.sv | 42 ++++
 rtl/usbf_dma_svc.sv | 165 ++++++++++++++++
 tb/tb_usbf_dma_svc.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usbf_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usbf_dma_pkg
// Description : Shared types and constants for the endpoint DMA service
//               block. It defines the service FSM state encoding, the counter
//               widths and the round-robin pointer increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package usbf_dma_pkg;

    localparam int EP_W    = 4;   // endpoint index width
    localparam int BURST_W = 4;   // words served in the current burst
    localparam int TO_W    = 8;   // bus response timeout counter

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_XFER = 3'd2,
        ST_ACK  = 3'd3,
        ST_GAP  = 3'd4
    } dma_state_e;

    // Next endpoint index after ch, wrapping at num_ep-1 back to 0.
    function automatic logic [EP_W-1:0] ep_next(input logic [EP_W-1:0] ch,
                                                input int              num_ep);
        ep_next = (int'(ch) >= num_ep - 1) ? '0 : ch + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usbf_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : usbf_rr_arb
// Description : Combinational round-robin find-first. It returns the first set
//               bit of elig_i, starting at ptr_i and searching upward, with a
//               wrap from NUM_EP-1 back to 0.
// Ports       : elig_i    - eligible request vector
//               ptr_i     - search start index (must be < NUM_EP)
//               gnt_idx_o - index of the granted request
//               gnt_vld_o - 1 when any request is eligible
// Revision    : 1.0 - initial release
// ============================================================================
module usbf_rr_arb
    import usbf_dma_pkg::*;
#(
    parameter int NUM_EP = 16
) (
    input  logic [NUM_EP-1:0] elig_i,
    input  logic [EP_W-1:0]   ptr_i,
    output logic [EP_W-1:0]   gnt_idx_o,
    output logic              gnt_vld_o
);

    // Rotate so bit 0 corresponds to the pointer position; the lowest set bit
    // of the rotated vector is then the winner.
    logic [NUM_EP-1:0] w_rot;
    assign w_rot = NUM_EP'({elig_i, elig_i} >> ptr_i);

    // Scan from the top so the lowest offset is assigned last and wins.
    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        for (int k = NUM_EP - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = EP_W'((int'(ptr_i) + k) % NUM_EP);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/usbf_dma_svc.sv
`default_nettype none
// ============================================================================
// Module      : usbf_dma_svc
// Description : Host-side responder for the endpoint DMA handshake. It
//               arbitrates the endpoint requests round-robin, with optional
//               same-channel bursts. Each granted word runs as one
//               bus_req/bus_ack handshake, and the block returns a one-cycle
//               dma_ack per completed word. A bus error or a timeout sets a
//               sticky per-channel error bit.
// Ports       : clk, rst (async, active-low)
//               en                - global enable
//               dma_req, ep_dir   - endpoint request level and direction
//               dma_ack           - one-hot single-cycle word acknowledge
//               bus_req/we/ep     - host bus request, direction and endpoint
//               bus_ack, bus_err  - host bus response
//               err_clr, err_stat - W1C clear and sticky error status
//               busy              - FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module usbf_dma_svc
    import usbf_dma_pkg::*;
#(
    parameter int NUM_EP    = 16,
    parameter int MAX_BURST = 4,
    parameter int TO_CYC    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_EP-1:0] dma_req,
    input  logic [NUM_EP-1:0] ep_dir,
    output logic [NUM_EP-1:0] dma_ack,
    output logic              bus_req,
    output logic              bus_we,
    output logic [EP_W-1:0]   bus_ep,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [NUM_EP-1:0] err_clr,
    output logic [NUM_EP-1:0] err_stat,
    output logic              busy
);

    localparam logic [NUM_EP-1:0] ONE = {{(NUM_EP-1){1'b0}}, 1'b1};

    dma_state_e           state_q, state_d;
    logic [EP_W-1:0]      ptr_q, ptr_d;
    logic [EP_W-1:0]      ch_q, ch_d;
    logic                 we_q, we_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic [NUM_EP-1:0]    err_q, err_d, err_set;
    logic [NUM_EP-1:0]    ack_q;
    logic                 breq_q, busy_q;

    logic [NUM_EP-1:0]    w_ch_oh, w_gnt_oh, w_mask, w_req_ok, w_elig;
    logic [EP_W-1:0]      w_gnt_idx;
    logic                 w_gnt_vld;

    assign w_ch_oh  = ONE << ch_q;
    assign w_gnt_oh = ONE << w_gnt_idx;
    // The channel just served may still show its stale request during GAP.
    assign w_mask   = (state_q == ST_GAP) ? w_ch_oh : '0;
    assign w_req_ok = dma_req & ~err_q;
    assign w_elig   = w_req_ok & ~w_mask;

    usbf_rr_arb #(
        .NUM_EP    (NUM_EP)
    ) u_arb (
        .elig_i    (w_elig),
        .ptr_i     (ptr_q),
        .gnt_idx_o (w_gnt_idx),
        .gnt_vld_o (w_gnt_vld)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        we_d    = we_q;
        burst_d = burst_q;
        to_d    = to_q;
        err_set = '0;
        case (state_q)
            ST_IDLE: begin
                if (en && (|w_elig)) state_d = ST_ARB;
            end
            ST_ARB: begin
                // Requests may have vanished since IDLE; fall back if so.
                if (w_gnt_vld) begin
                    state_d = ST_XFER;
                    ch_d    = w_gnt_idx;
                    we_d    = ~|(ep_dir & w_gnt_oh);
                    burst_d = '0;
                    to_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                // The last counted cycle without a response is the timeout.
                if (bus_err || (!bus_ack && (to_q == TO_W'(TO_CYC - 1)))) begin
                    err_set = w_ch_oh;
                    state_d = ST_GAP;
                end else if (bus_ack) begin
                    state_d = ST_ACK;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_ACK: begin
                burst_d = burst_q + 1'b1;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (en && (|(w_req_ok & w_ch_oh)) &&
                    (burst_q < BURST_W'(MAX_BURST))) begin
                    state_d = ST_XFER;
                    to_d    = '0;
                end else begin
                    ptr_d   = ep_next(ch_q, NUM_EP);
                    state_d = (en && (|w_req_ok)) ? ST_ARB : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new error beats a simultaneous clear of the same bit.
        err_d = (err_q & ~err_clr) | err_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            ch_q    <= '0;
            we_q    <= 1'b0;
            burst_q <= '0;
            to_q    <= '0;
            err_q   <= '0;
            ack_q   <= '0;
            breq_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            we_q    <= we_d;
            burst_q <= burst_d;
            to_q    <= to_d;
            err_q   <= err_d;
            // Outputs are registered so they line up with the state they flag.
            ack_q   <= (state_d == ST_ACK) ? w_ch_oh : '0;
            breq_q  <= (state_d == ST_XFER);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign dma_ack  = ack_q;
    assign bus_req  = breq_q;
    assign bus_we   = we_q;
    assign bus_ep   = ch_q;
    assign err_stat = err_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_usbf_dma_svc.sv
`default_nettype none
// ============================================================================
// Module      : tb_usbf_dma_svc
// Description : Self-checking bench for usbf_dma_svc (NUM_EP=16, MAX_BURST=4,
//               TO_CYC=8). It applies a cycle table, then hand-written corner
//               sequences, then random endpoint and bus traffic checked
//               against a transaction-level round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usbf_dma_svc;

    localparam int N     = 16;
    localparam int BURST = 4;
    localparam int TOC   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [N-1:0]  dma_req, ep_dir, dma_ack, err_clr, err_stat;
    logic          bus_req, bus_we, bus_ack, bus_err, busy;
    logic [3:0]    bus_ep;

    usbf_dma_svc #(.NUM_EP(N), .MAX_BURST(BURST), .TO_CYC(TOC)) dut (
        .clk(clk), .rst(rst), .en(en), .dma_req(dma_req), .ep_dir(ep_dir),
        .dma_ack(dma_ack), .bus_req(bus_req), .bus_we(bus_we), .bus_ep(bus_ep),
        .bus_ack(bus_ack), .bus_err(bus_err), .err_clr(err_clr),
        .err_stat(err_stat), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed observation {bus_req, bus_we, bus_ep, dma_ack, err_stat, busy}.
    function automatic logic [38:0] obs();
        return {bus_req, bus_we, bus_ep, dma_ack, err_stat, busy};
    endfunction

    // ---------------- reference model state ----------------
    typedef struct { int ch; logic we; logic err; } word_t;
    word_t        expq[$];
    int           ep_rem[N];
    logic [N-1:0] m_err;
    logic [N-1:0] dir_r;
    int           m_ptr;

    task automatic do_reset();
        rst = 1'b0; en = 1'b1; dma_req = '0; bus_ack = 1'b0; bus_err = 1'b0;
        err_clr = '0; ep_dir = dir_r;
        tick(); tick();
        rst = 1'b1;
        tick();
        m_ptr = 0; m_err = '0; expq.delete();
    endtask

    // Words the DUT must run, given each endpoint's word count, the pointer
    // and the error bits: round-robin channel choice, then up to BURST words
    // on that channel, a failed word ending the channel's service.
    task automatic plan(input int errpct);
        int rem[N];
        logic [N-1:0] er;
        int ch, served, idx;
        word_t w;
        for (int i = 0; i < N; i++) rem[i] = ep_rem[i];
        er = m_err;
        forever begin
            ch = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (ch < 0 && rem[idx] > 0 && !er[idx]) ch = idx;
            end
            if (ch < 0) break;
            served = 0;
            while (served < BURST && rem[ch] > 0 && !er[ch]) begin
                w.ch  = ch;
                w.we  = ~dir_r[ch];
                w.err = ($urandom_range(99) < errpct);
                expq.push_back(w);
                if (w.err) er[ch] = 1'b1;
                else begin rem[ch]--; served++; end
            end
            m_ptr = (ch + 1) % N;
        end
        m_err = er;
    endtask

    // Acts as the endpoints (request while words remain) and as the bus
    // (respond after a random delay) while scoring each word.
    task automatic run_words(input string tag, input int budget);
        bit active, ack_pend, done;
        int delay, ack_ch;
        word_t cur;
        logic [N-1:0] one;
        one = 1; active = 0; ack_pend = 0; done = 0; delay = 0; ack_ch = 0;
        for (int i = 0; i < N; i++) dma_req[i] = (ep_rem[i] > 0);
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            tick();
            if (ack_pend) begin
                check({tag, "_ack"}, dma_ack, one << ack_ch);
                ack_pend = 0;
            end else if (dma_ack != '0) begin
                check({tag, "_spurious_ack"}, dma_ack, 0);
            end
            for (int i = 0; i < N; i++)
                if (dma_ack[i] && ep_rem[i] > 0) ep_rem[i]--;
            bus_ack = 1'b0; bus_err = 1'b0;
            if (bus_req) begin
                if (!active) begin
                    if (expq.size() == 0) begin
                        check({tag, "_unexpected_word_ep"}, bus_ep, 5'h1f);
                    end else begin
                        cur = expq.pop_front();
                        check({tag, "_bus_ep"}, bus_ep, cur.ch);
                        check({tag, "_bus_we"}, bus_we, cur.we);
                        active = 1; delay = $urandom_range(3);
                    end
                end
                if (active) begin
                    if (delay == 0) begin
                        if (cur.err) begin
                            bus_err = 1'b1; bus_ack = 1'($urandom_range(1));
                        end else begin
                            bus_ack = 1'b1; ack_pend = 1; ack_ch = cur.ch;
                        end
                        active = 0;
                    end else begin
                        delay--;
                    end
                end
            end else begin
                if (active) begin
                    check({tag, "_bus_req_dropped"}, bus_req, 1);
                    active = 0;
                end
                // Responses outside a request must be ignored.
                bus_ack = ($urandom_range(3) == 0);
                bus_err = ($urandom_range(5) == 0);
            end
            for (int i = 0; i < N; i++) dma_req[i] = (ep_rem[i] > 0);
            if (expq.size() == 0 && !active && !ack_pend && !busy) done = 1;
        end
        bus_ack = 1'b0; bus_err = 1'b0;
        check({tag, "_finished_in_budget"}, done, 1);
        check({tag, "_words_left"}, expq.size(), 0);
        check({tag, "_err_stat"}, err_stat, m_err);
        expq.delete();
    endtask

    task automatic wait_breq(input string nm);
        for (int k = 0; k < 30 && !bus_req; k++) tick();
        check(nm, bus_req, 1);
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic en; logic [N-1:0] req; logic ack; logic err; logic [N-1:0] clr;
        logic [38:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input logic e, input logic [15:0] rq, input logic a,
                                input logic er, input logic [15:0] cl,
                                input logic xb, input logic xw, input logic [3:0] xe,
                                input logic [15:0] xa, input logic [15:0] xs,
                                input logic xy);
        vec_t v;
        v.en = e; v.req = rq; v.ack = a; v.err = er; v.clr = cl;
        v.exp = {xb, xw, xe, xa, xs, xy};
        return v;
    endfunction

    logic [15:0] acks_seen;
    int          ack_times[$];

    initial begin
        // Table: single word on ch3 (OUT), then a timeout on ch2 (IN), an
        // error clear, and a successful retry on ch2.
        //             en req      ack err clr      breq we ep  dack     est      busy
        vecs.push_back(mk(1, 16'h0008, 0, 0, 16'h0, 0, 0, 0, 16'h0,    16'h0,    1));
        vecs.push_back(mk(1, 16'h0008, 0, 0, 16'h0, 1, 1, 3, 16'h0,    16'h0,    1));
        vecs.push_back(mk(1, 16'h0008, 0, 0, 16'h0, 1, 1, 3, 16'h0,    16'h0,    1));
        vecs.push_back(mk(1, 16'h0008, 1, 0, 16'h0, 0, 1, 3, 16'h0008, 16'h0,    1));
        vecs.push_back(mk(1, 16'h0000, 0, 0, 16'h0, 0, 1, 3, 16'h0,    16'h0,    1));
        vecs.push_back(mk(1, 16'h0000, 0, 0, 16'h0, 0, 1, 3, 16'h0,    16'h0,    0));
        vecs.push_back(mk(1, 16'h0000, 0, 0, 16'h0, 0, 1, 3, 16'h0,    16'h0,    0));
        vecs.push_back(mk(1, 16'h0004, 0, 0, 16'h0, 0, 1, 3, 16'h0,    16'h0,    1));
        vecs.push_back(mk(1, 16'h0004, 0, 0, 16'h0, 1, 0, 2, 16'h0,    16'h0,    1));
        for (int i = 0; i < TOC - 1; i++)
            vecs.push_back(mk(1, 16'h0004, 0, 0, 16'h0, 1, 0, 2, 16'h0, 16'h0,   1));
        vecs.push_back(mk(1, 16'h0004, 0, 0, 16'h0, 0, 0, 2, 16'h0,    16'h0004, 1));
        vecs.push_back(mk(1, 16'h0004, 0, 0, 16'h0, 0, 0, 2, 16'h0,    16'h0004, 0));
        vecs.push_back(mk(1, 16'h0004, 0, 0, 16'h0, 0, 0, 2, 16'h0,    16'h0004, 0));
        vecs.push_back(mk(1, 16'h0004, 0, 0, 16'h4, 0, 0, 2, 16'h0,    16'h0,    0));
        vecs.push_back(mk(1, 16'h0004, 0, 0, 16'h0, 0, 0, 2, 16'h0,    16'h0,    1));
        vecs.push_back(mk(1, 16'h0004, 0, 0, 16'h0, 1, 0, 2, 16'h0,    16'h0,    1));
        vecs.push_back(mk(1, 16'h0004, 1, 0, 16'h0, 0, 0, 2, 16'h0004, 16'h0,    1));
        vecs.push_back(mk(1, 16'h0000, 0, 0, 16'h0, 0, 0, 2, 16'h0,    16'h0,    1));
        vecs.push_back(mk(1, 16'h0000, 0, 0, 16'h0, 0, 0, 2, 16'h0,    16'h0,    0));

        dir_r = 16'h0004;
        rst = 1'b0; en = 1'b1; dma_req = '0; ep_dir = dir_r;
        bus_ack = 1'b0; bus_err = 1'b0; err_clr = '0;
        #1;
        check("reset_outputs_async", obs(), 39'h0);
        do_reset();
        check("reset_outputs", obs(), 39'h0);

        for (int r = 0; r < vecs.size(); r++) begin
            en = vecs[r].en; dma_req = vecs[r].req; bus_ack = vecs[r].ack;
            bus_err = vecs[r].err; err_clr = vecs[r].clr;
            tick();
            check($sformatf("vec%0d", r), obs(), vecs[r].exp);
        end
        err_clr = '0; bus_ack = 1'b0;

        // Burst on ch5 with an always-ready bus: four acks 3 cycles apart,
        // then re-arbitration, which picks ch5 again as it is alone.
        dir_r = '0; do_reset();
        dma_req = 16'h0020; bus_ack = 1'b1;
        ack_times.delete();
        for (int s = 1; s <= 17; s++) begin
            tick();
            if (dma_ack != '0) begin
                ack_times.push_back(s);
                check("burst_ack_ch", dma_ack, 16'h0020);
            end
            if (s == 14) check("burst_rearb_gap", {bus_req, busy}, 2'b01);
        end
        check("burst_ack_count", ack_times.size(), 5);
        if (ack_times.size() == 5) begin
            check("burst_ack0", ack_times[0], 3);
            check("burst_ack1", ack_times[1], 6);
            check("burst_ack2", ack_times[2], 9);
            check("burst_ack3", ack_times[3], 12);
            check("burst_regrant", ack_times[4], 16);
        end
        bus_ack = 1'b0; dma_req = '0;

        // bus_err and bus_ack together on ch7: error wins, no ack.
        do_reset();
        dma_req = 16'h0080;
        wait_breq("err7_bus_req");
        check("err7_bus_ep", bus_ep, 7);
        bus_ack = 1'b1; bus_err = 1'b1;
        tick();
        bus_ack = 1'b0; bus_err = 1'b0;
        check("err7_err_stat", err_stat, 16'h0080);
        acks_seen = dma_ack;
        for (int s = 0; s < 4; s++) begin tick(); acks_seen |= dma_ack; end
        check("err7_no_ack", acks_seen, 16'h0);
        check("err7_skipped_idle", busy, 0);

        // Async reset while ch1 is mid-transfer (ch7 still in error).
        dma_req = 16'h0082;
        wait_breq("rst_bus_req");
        check("rst_bus_ep", bus_ep, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_clear", {bus_req, dma_ack, err_stat, busy}, 34'h0);
        tick();
        dma_req = 16'h8002;
        #2 rst = 1'b1;
        #1;
        check("rst_release_idle", busy, 0);
        wait_breq("rst_ptr_bus_req");
        check("rst_ptr_zero_grant", bus_ep, 1);
        dma_req = '0;

        // en dropped while ch6 is on the bus: word still acked, then idle.
        do_reset();
        dma_req = 16'h0140;
        wait_breq("en_bus_req");
        check("en_bus_ep", bus_ep, 6);
        en = 1'b0;
        tick();
        check("en_word_held", bus_req, 1);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("en_word_acked", dma_ack, 16'h0040);
        dma_req = 16'h0100;
        tick(); tick();
        acks_seen = {15'h0, busy};
        for (int s = 0; s < 5; s++) begin tick(); acks_seen[0] |= busy | bus_req; end
        check("en_stays_idle", acks_seen, 16'h0);
        en = 1'b1;
        wait_breq("en_resume_bus_req");
        check("en_resume_ep", bus_ep, 8);
        dma_req = '0;

        // Round robin over 0,4,8 then a wrap: with ptr past 8, 12 precedes 0.
        dir_r = 16'($urandom); do_reset();
        for (int i = 0; i < N; i++) ep_rem[i] = 0;
        ep_rem[0] = 1; ep_rem[4] = 1; ep_rem[8] = 1;
        plan(0);
        run_words("rr", 300);
        ep_rem[0] = 1; ep_rem[12] = 1;
        plan(0);
        run_words("rr_wrap", 300);

        // Random traffic with occasional bus errors.
        for (int r = 0; r < 5; r++) begin
            dir_r = 16'($urandom); do_reset();
            for (int i = 0; i < N; i++)
                ep_rem[i] = ($urandom_range(2) == 0) ? 0 : int'($urandom_range(6, 1));
            plan(12);
            run_words($sformatf("rand%0d", r), 4000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
